// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the bridge state encoding, imported by the bridge and by
// wstrb_gen (which the d-cache also reuses).
package axi_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdA,
    StRdD,
    StWrAw,
    StWrB
  } bridge_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/wstrb_gen.sv
// Combinational byte-lane strobe from access size and the low address bits.
// Half-word accesses are aligned down to an even lane pair; size 3 behaves as a word.
module wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] wstrb
);

  always_comb begin
    wstrb = 4'b1111;
    case (size)
      SIZE_BYTE: wstrb = 4'b0001 << addr_lo;
      SIZE_HALF: wstrb = 4'b0011 << {addr_lo[1], 1'b0};
      default:   wstrb = 4'b1111;
    endcase
  end

endmodule

// File: rtl/sram_axi_bridge.sv
// sram-like responder to single-beat AXI4 master, one transaction in flight at a time.
// Define SRAM_AXI_BRIDGE_ERR_EN to add the err output flagging non-OKAY responses.
module sram_axi_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0]  AXI_ID     = 4'd0,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  // sram-like side
  input  logic                    req,
  input  logic                    wr,
  input  logic [1:0]              size,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    addr_ok,
  output logic                    data_ok,
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  output logic                    err,
`endif
  // AXI read address
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [3:0]              arid,
  output logic                    arvalid,
  input  logic                    arready,
  // AXI read data
  input  logic [DATA_WIDTH-1:0]   rdata_m,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic [3:0]              rid,
  input  logic                    rvalid,
  output logic                    rready,
  // AXI write address
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [3:0]              awid,
  output logic                    awvalid,
  input  logic                    awready,
  // AXI write data
  output logic [DATA_WIDTH-1:0]   wdata_m,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // AXI write response
  input  logic [1:0]              bresp,
  input  logic [3:0]              bid,
  input  logic                    bvalid,
  output logic                    bready
);

  bridge_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [1:0]             size_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic                   aw_done_q, aw_done_d;
  logic                   w_done_q, w_done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      if (addr_ok) begin
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
      end
    end
  end

  // All handshake outputs are forced low while rst is high, regardless of state.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    addr_ok   = 1'b0;
    data_ok   = 1'b0;
    rdata     = '0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          addr_ok = req;
          if (req) begin
            state_d   = wr ? StWrAw : StRdA;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
        StRdA: begin
          arvalid = 1'b1;
          if (arready) state_d = StRdD;
        end
        StRdD: begin
          rready = 1'b1;
          if (rvalid) begin
            data_ok = 1'b1;
            rdata   = rdata_m;
            state_d = StIdle;
          end
        end
        StWrAw: begin
          awvalid   = !aw_done_q;
          wvalid    = !w_done_q;
          aw_done_d = aw_done_q | (awvalid & awready);
          w_done_d  = w_done_q | (wvalid & wready);
          if (aw_done_d && w_done_d) begin
            state_d   = StWrB;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
          end
        end
        StWrB: begin
          bready = 1'b1;
          if (bvalid) begin
            data_ok = 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign araddr  = addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, size_q};
  assign arburst = AXI_BURST_INCR;
  assign arid    = AXI_ID;

  assign awaddr  = addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, size_q};
  assign awburst = AXI_BURST_INCR;
  assign awid    = AXI_ID;

  assign wdata_m = wdata_q;
  assign wlast   = 1'b1;

  wstrb_gen u_wstrb_gen (
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .wstrb   (wstrb)
  );

  // Single beat with a fixed ID: rlast/rid/bid carry no information here.
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  assign err = data_ok &&
               ((state_q == StRdD) ? (rresp != AXI_RESP_OKAY) : (bresp != AXI_RESP_OKAY));
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rid, bid};
`else
  logic unused_inputs;
  assign unused_inputs = ^{rlast, rid, bid, rresp, bresp};
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: a vector table of single transactions with per-channel
// slave wait states, plus hand sequences for back-to-back, reset mid-read and reset state.
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, wr;
  logic [1:0]  size;
  logic [31:0] addr, wdata, rdata;
  logic        addr_ok, data_ok;
  logic [31:0] araddr, awaddr, wdata_m, rdata_m;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic [3:0]  arid, awid, rid, bid, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_axi_bridge dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .wr      (wr),
    .size    (size),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .addr_ok (addr_ok),
    .data_ok (data_ok),
`ifdef SRAM_AXI_BRIDGE_ERR_EN
    .err     (err),
`endif
    .araddr  (araddr),
    .arlen   (arlen),
    .arsize  (arsize),
    .arburst (arburst),
    .arid    (arid),
    .arvalid (arvalid),
    .arready (arready),
    .rdata_m (rdata_m),
    .rresp   (rresp),
    .rlast   (rlast),
    .rid     (rid),
    .rvalid  (rvalid),
    .rready  (rready),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awsize  (awsize),
    .awburst (awburst),
    .awid    (awid),
    .awvalid (awvalid),
    .awready (awready),
    .wdata_m (wdata_m),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bid     (bid),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  // a_wait: cycles before AR/AW ready; d_wait: before rvalid (read) or wready (write)
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdm;
    logic [1:0]  resp;
    int          a_wait;
    int          d_wait;
    int          b_wait;
    logic [3:0]  strb;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    arready = 1'b0; rvalid = 1'b0; rdata_m = 32'h0; rresp = 2'b00;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
  endtask

  task automatic chk_all_quiet(input string tag);
    chk({tag, "_arvalid"}, {31'b0, arvalid}, 32'd0);
    chk({tag, "_rready"},  {31'b0, rready},  32'd0);
    chk({tag, "_awvalid"}, {31'b0, awvalid}, 32'd0);
    chk({tag, "_wvalid"},  {31'b0, wvalid},  32'd0);
    chk({tag, "_bready"},  {31'b0, bready},  32'd0);
    chk({tag, "_data_ok"}, {31'b0, data_ok}, 32'd0);
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int n;
    req = 1'b1; wr = v.wr; size = v.size; addr = v.addr; wdata = v.wdata;
    #1;
    chk($sformatf("v%0d_addr_ok", idx), {31'b0, addr_ok}, 32'd1);
    step();
    // Busy: a conflicting request stays asserted and must be ignored.
    wr = ~v.wr; size = ~v.size; addr = ~v.addr; wdata = ~v.wdata;
    if (!v.wr) begin
      for (int k = 0; k <= v.a_wait; k++) begin
        arready = (k == v.a_wait);
        #1;
        chk($sformatf("v%0d_arvalid", idx), {31'b0, arvalid}, 32'd1);
        chk($sformatf("v%0d_araddr", idx), araddr, v.addr);
        chk($sformatf("v%0d_arsize", idx), {29'b0, arsize}, {30'b0, v.size});
        chk($sformatf("v%0d_arlen_burst_id", idx), {16'b0, arlen, 2'b0, arburst, arid},
            {16'b0, 8'd0, 2'b0, 2'b01, 4'd0});
        chk($sformatf("v%0d_rd_busy", idx), {29'b0, rready, data_ok, addr_ok}, 32'd0);
        step();
      end
      arready = 1'b0;
      for (int k = 0; k <= v.d_wait; k++) begin
        rvalid  = (k == v.d_wait);
        rdata_m = (k == v.d_wait) ? v.rdm : 32'hFFFF_FFFF;
        rresp   = v.resp;
        #1;
        chk($sformatf("v%0d_rready", idx), {31'b0, rready}, 32'd1);
        chk($sformatf("v%0d_rd_data_ok", idx), {31'b0, data_ok}, {31'b0, k == v.d_wait});
        chk($sformatf("v%0d_rd_addr_ok", idx), {30'b0, arvalid, addr_ok}, 32'd0);
        if (k == v.d_wait) begin
          chk($sformatf("v%0d_rdata", idx), rdata, v.rdm);
`ifdef SRAM_AXI_BRIDGE_ERR_EN
          chk($sformatf("v%0d_rd_err", idx), {31'b0, err}, {31'b0, v.resp != 2'b00});
`endif
        end
        step();
      end
    end else begin
      n = (v.a_wait > v.d_wait) ? v.a_wait : v.d_wait;
      for (int k = 0; k <= n; k++) begin
        awready = (k == v.a_wait);
        wready  = (k == v.d_wait);
        #1;
        chk($sformatf("v%0d_awvalid_k%0d", idx, k), {31'b0, awvalid}, {31'b0, k <= v.a_wait});
        chk($sformatf("v%0d_wvalid_k%0d", idx, k), {31'b0, wvalid}, {31'b0, k <= v.d_wait});
        chk($sformatf("v%0d_wr_busy", idx), {29'b0, bready, data_ok, addr_ok}, 32'd0);
        if (k <= v.a_wait) begin
          chk($sformatf("v%0d_awaddr", idx), awaddr, v.addr);
          chk($sformatf("v%0d_awsize", idx), {29'b0, awsize}, {30'b0, v.size});
          chk($sformatf("v%0d_awlen_burst_id", idx), {16'b0, awlen, 2'b0, awburst, awid},
              {16'b0, 8'd0, 2'b0, 2'b01, 4'd0});
        end
        if (k <= v.d_wait) begin
          chk($sformatf("v%0d_wdata_m", idx), wdata_m, v.wdata);
          chk($sformatf("v%0d_wstrb", idx), {28'b0, wstrb}, {28'b0, v.strb});
          chk($sformatf("v%0d_wlast", idx), {31'b0, wlast}, 32'd1);
        end
        step();
      end
      awready = 1'b0; wready = 1'b0;
      for (int k = 0; k <= v.b_wait; k++) begin
        bvalid = (k == v.b_wait);
        bresp  = v.resp;
        #1;
        chk($sformatf("v%0d_bready", idx), {31'b0, bready}, 32'd1);
        chk($sformatf("v%0d_b_valids", idx), {29'b0, awvalid, wvalid, addr_ok}, 32'd0);
        chk($sformatf("v%0d_wr_data_ok", idx), {31'b0, data_ok}, {31'b0, k == v.b_wait});
`ifdef SRAM_AXI_BRIDGE_ERR_EN
        if (k == v.b_wait)
          chk($sformatf("v%0d_wr_err", idx), {31'b0, err}, {31'b0, v.resp != 2'b00});
`endif
        step();
      end
    end
    slave_idle();
    req = 1'b0;
    #1;
    chk($sformatf("v%0d_after", idx), {30'b0, data_ok, addr_ok}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 2'd2, 32'hBFC0_0000, 32'h0,         32'h3C1D_BFC0, 2'b00, 0, 0, 0, 4'h0};
    vecs[1]  = '{1'b1, 2'd0, 32'h8000_0003, 32'hAB00_0000, 32'h0,         2'b00, 0, 0, 0, 4'b1000};
    vecs[2]  = '{1'b1, 2'd1, 32'h8000_0002, 32'h1234_0000, 32'h0,         2'b00, 0, 0, 0, 4'b1100};
    vecs[3]  = '{1'b1, 2'd1, 32'h8000_0001, 32'h0000_5678, 32'h0,         2'b00, 0, 0, 0, 4'b0011};
    vecs[4]  = '{1'b1, 2'd0, 32'h8000_0001, 32'h0000_9A00, 32'h0,         2'b00, 0, 0, 1, 4'b0010};
    vecs[5]  = '{1'b0, 2'd0, 32'h0000_1001, 32'h0,         32'h1234_5678, 2'b00, 2, 1, 0, 4'h0};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         2'b00, 3, 0, 0, 4'b1111};
    vecs[7]  = '{1'b1, 2'd3, 32'h0000_0020, 32'h0BAD_CAFE, 32'h0,         2'b00, 0, 2, 2, 4'b1111};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000_0030, 32'h5555_AAAA, 32'h0,         2'b10, 0, 0, 0, 4'b1111};
    vecs[9]  = '{1'b0, 2'd2, 32'h0000_0040, 32'h0,         32'hCAFE_F00D, 2'b00, 0, 0, 0, 4'h0};
    vecs[10] = '{1'b0, 2'd1, 32'h0000_0006, 32'h0,         32'h0000_BEEF, 2'b11, 1, 0, 0, 4'h0};

    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0; addr = 32'h0; wdata = 32'h0;
    rlast = 1'b1; rid = 4'd0; bid = 4'd0;
    slave_idle();

    // Reset state, with a request pending that must not be accepted.
    step();
    req = 1'b1;
    #1;
    chk("rst_addr_ok", {31'b0, addr_ok}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk_all_quiet("rst");
    step();
    rst = 1'b0; req = 1'b0;
    #1;
    chk_all_quiet("post_rst");

    foreach (vecs[i]) do_txn(vecs[i], i);

    // Back-to-back reads with req held high.
    step();
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0100;
    #1;
    chk("b2b_addr_ok0", {31'b0, addr_ok}, 32'd1);
    step();
    addr = 32'h0000_0200; arready = 1'b1;
    #1;
    chk("b2b_araddr0", araddr, 32'h0000_0100);
    chk("b2b_busy0", {31'b0, addr_ok}, 32'd0);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata_m = 32'h1111_0000;
    #1;
    chk("b2b_data_ok0", {31'b0, data_ok}, 32'd1);
    chk("b2b_rdata0", rdata, 32'h1111_0000);
    chk("b2b_busy_dok", {31'b0, addr_ok}, 32'd0);
    step();
    rvalid = 1'b0;
    #1;
    chk("b2b_addr_ok1", {31'b0, addr_ok}, 32'd1);
    chk("b2b_idle_dok", {31'b0, data_ok}, 32'd0);
    step();
    req = 1'b0; arready = 1'b1;
    #1;
    chk("b2b_araddr1", araddr, 32'h0000_0200);
    step();
    arready = 1'b0; rvalid = 1'b1; rdata_m = 32'h2222_0000;
    #1;
    chk("b2b_data_ok1", {31'b0, data_ok}, 32'd1);
    chk("b2b_rdata1", rdata, 32'h2222_0000);
    step();
    slave_idle();

    // Reset while waiting in RD_D; a stray rvalid afterwards must not complete anything.
    req = 1'b1; wr = 1'b0; size = 2'd2; addr = 32'h0000_0300;
    #1;
    chk("rstmid_addr_ok", {31'b0, addr_ok}, 32'd1);
    step();
    req = 1'b0; arready = 1'b1;
    #1;
    chk("rstmid_arvalid", {31'b0, arvalid}, 32'd1);
    step();
    arready = 1'b0;
    #1;
    chk("rstmid_rready", {31'b0, rready}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; rvalid = 1'b1; rdata_m = 32'h3333_3333;
    #1;
    chk_all_quiet("rstmid_after");
    step();
    slave_idle();
    do_txn(vecs[0], 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
